// File: rtl/synth_ctrl_pkg.sv
// Shared types and widths for the voice allocator and its per-voice envelope.
package synth_ctrl_pkg;

   localparam int unsigned MAX_VOICES = 8;
   localparam int unsigned NOTE_W     = 7;
   localparam int unsigned VEL_W      = 7;
   localparam int unsigned FREQ_W     = 32;
   localparam int unsigned VOL_W      = 32;

   typedef enum logic [1:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } alloc_state_t;

   typedef struct packed {
      logic              on;
      logic [NOTE_W-1:0] note;
      logic [VEL_W-1:0]  velocity;
      logic [FREQ_W-1:0] freq;
   } note_event_t;

endpackage

// File: rtl/voice_envelope.sv
// One voice's linear attack/sustain/release envelope. Commands from the
// allocator take precedence over the envelope tick in the same cycle.
module voice_envelope
   import synth_ctrl_pkg::*;
#(
   parameter logic [VOL_W-1:0] ATTACK_STEP  = 32'h0100_0000,
   parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0040_0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic             i_retrig,
   input  logic             i_release,
   input  logic [VOL_W-1:0] i_target,
   output env_state_t       o_state,
   output logic [VOL_W-1:0] o_volume,
   output logic             o_active
);

   env_state_t       r_state,  w_state_nxt;
   logic [VOL_W-1:0] r_volume, w_vol_nxt;
   logic [VOL_W-1:0] r_target, w_target_nxt;
   logic             r_active;
   logic [VOL_W:0]   w_sum;

   // Next envelope state: commands first, otherwise the tick ramp.
   always_comb begin
      w_state_nxt  = r_state;
      w_vol_nxt    = r_volume;
      w_target_nxt = r_target;
      w_sum        = {1'b0, r_volume} + {1'b0, ATTACK_STEP};
      if (i_load) begin
         w_vol_nxt    = '0;
         w_target_nxt = i_target;
         w_state_nxt  = ENV_ATTACK;
      end else if (i_retrig) begin
         w_target_nxt = i_target;
         w_state_nxt  = ENV_ATTACK;
      end else if (i_release) begin
         w_state_nxt  = ENV_RELEASE;
      end else if (i_tick) begin
         case (r_state)
            ENV_ATTACK: begin
               if (w_sum >= {1'b0, r_target}) begin
                  w_vol_nxt   = r_target;
                  w_state_nxt = ENV_SUSTAIN;
               end else begin
                  w_vol_nxt   = w_sum[VOL_W-1:0];
               end
            end
            ENV_RELEASE: begin
               if (r_volume <= RELEASE_STEP) begin
                  w_vol_nxt   = '0;
                  w_state_nxt = ENV_IDLE;
               end else begin
                  w_vol_nxt   = r_volume - RELEASE_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   // Envelope registers; active flag tracks the registered state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ENV_IDLE;
         r_volume <= '0;
         r_target <= '0;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_volume <= w_vol_nxt;
         r_target <= w_target_nxt;
         r_active <= (w_state_nxt != ENV_IDLE);
      end
   end

   assign o_state  = r_state;
   assign o_volume = r_volume;
   assign o_active = r_active;

endmodule

// File: rtl/voice_allocator.sv
// Event-to-voice allocator for the polyphonic synth: accepts note events,
// scans voices one per cycle, then commits an allocate/retrigger/release.
// Optional build macro VOICE_ALLOC_STEAL_EN: steal the oldest voice when
// none is free; otherwise such note-ons are dropped and counted.
module voice_allocator
   import synth_ctrl_pkg::*;
#(
   parameter int unsigned      NUM_VOICES   = 8,
   parameter int unsigned      ENV_DIV      = 48000,
   parameter logic [VOL_W-1:0] ATTACK_STEP  = 32'h0100_0000,
   parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0040_0000,
   parameter int unsigned      VOL_SHIFT    = 24
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                ev_valid,
   output logic                                ev_ready,
   input  logic                                ev_on,
   input  logic [NOTE_W-1:0]                   ev_note,
   input  logic [VEL_W-1:0]                    ev_velocity,
   input  logic [FREQ_W-1:0]                   ev_freq,
   output logic [NUM_VOICES-1:0][FREQ_W-1:0]   frequencies,
   output logic [NUM_VOICES-1:0][VOL_W-1:0]    voice_volumes,
   output logic [NUM_VOICES-1:0]               voice_active,
   output logic [15:0]                         drop_count
);

   localparam int unsigned     IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   alloc_state_t      r_state, w_state_nxt;
   note_event_t       r_ev;
   logic              r_ev_ready, r_rst_done;
   logic [IDX_W-1:0]  r_scan_idx;
   logic              r_hit_vld, r_free_vld;
   logic [IDX_W-1:0]  r_hit_idx, r_free_idx;
`ifdef VOICE_ALLOC_STEAL_EN
   logic [IDX_W-1:0]  r_old_idx;
`endif
   logic [FREQ_W-1:0] r_freq [NUM_VOICES];
   logic [NOTE_W-1:0] r_note [NUM_VOICES];
   logic [IDX_W-1:0]  r_age  [NUM_VOICES];
   logic [31:0]       r_presc;
   logic [15:0]       r_drop;

   env_state_t        w_env_state [NUM_VOICES];
   logic              w_accept, w_tick, w_hit_cond, w_free_cond;
   logic              w_load, w_retrig, w_release, w_drop;
   logic [IDX_W-1:0]  w_sel_idx;
   logic [VOL_W-1:0]  w_target;

   assign w_accept    = (r_state == IDLE) && ev_valid && r_ev_ready;
   assign w_tick      = (r_presc == 32'(ENV_DIV - 1));
   assign w_hit_cond  = (r_note[r_scan_idx] == r_ev.note) &&
                        ((w_env_state[r_scan_idx] == ENV_ATTACK) ||
                         (w_env_state[r_scan_idx] == ENV_SUSTAIN));
   assign w_free_cond = (w_env_state[r_scan_idx] == ENV_IDLE);
   assign w_target    = VOL_W'(r_ev.velocity) << VOL_SHIFT;

   // Allocation FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and commit decision from the scan results.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_retrig    = 1'b0;
      w_release   = 1'b0;
      w_drop      = 1'b0;
      w_sel_idx   = '0;
      case (r_state)
         IDLE:   if (w_accept) w_state_nxt = SCAN;
         SCAN:   if (r_scan_idx == LAST_IDX) w_state_nxt = COMMIT;
         COMMIT: begin
            w_state_nxt = IDLE;
            if (r_ev.on) begin
               if (r_hit_vld) begin
                  w_retrig  = 1'b1;
                  w_sel_idx = r_hit_idx;
               end else if (r_free_vld) begin
                  w_load    = 1'b1;
                  w_sel_idx = r_free_idx;
               end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                  w_load    = 1'b1;
                  w_sel_idx = r_old_idx;
`else
                  w_drop    = 1'b1;
`endif
               end
            end else if (r_hit_vld) begin
               w_release = 1'b1;
               w_sel_idx = r_hit_idx;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake ready: high in IDLE, held off one extra cycle after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_done <= 1'b0;
         r_ev_ready <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         r_ev_ready <= r_rst_done && (w_state_nxt == IDLE);
      end
   end

   // Event latch and per-voice scan accumulation (lowest index wins).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ev       <= '0;
         r_scan_idx <= '0;
         r_hit_vld  <= 1'b0;
         r_hit_idx  <= '0;
         r_free_vld <= 1'b0;
         r_free_idx <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
         r_old_idx  <= '0;
`endif
      end else if (w_accept) begin
         r_ev       <= '{on: ev_on, note: ev_note, velocity: ev_velocity, freq: ev_freq};
         r_scan_idx <= '0;
         r_hit_vld  <= 1'b0;
         r_free_vld <= 1'b0;
      end else if (r_state == SCAN) begin
         r_scan_idx <= r_scan_idx + IDX_W'(1);
         if (w_hit_cond && !r_hit_vld) begin
            r_hit_vld <= 1'b1;
            r_hit_idx <= r_scan_idx;
         end
         if (w_free_cond && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_scan_idx;
         end
`ifdef VOICE_ALLOC_STEAL_EN
         if (r_age[r_scan_idx] == LAST_IDX) r_old_idx <= r_scan_idx;
`endif
      end
   end

   // Per-voice frequency, note tag and age bookkeeping on allocate/retrigger.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < NUM_VOICES; j++) begin
            r_freq[j] <= FREQ_W'(1);
            r_note[j] <= '0;
            r_age[j]  <= IDX_W'(j);
         end
      end else if (w_load || w_retrig) begin
         r_freq[w_sel_idx] <= r_ev.freq;
         r_note[w_sel_idx] <= r_ev.note;
         for (int j = 0; j < NUM_VOICES; j++) begin
            if (IDX_W'(j) == w_sel_idx)          r_age[j] <= '0;
            else if (r_age[j] < r_age[w_sel_idx]) r_age[j] <= r_age[j] + IDX_W'(1);
         end
      end
   end

   // Envelope prescaler and saturating drop counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0;
         r_drop  <= '0;
      end else begin
         r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
         if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      voice_envelope #(
         .ATTACK_STEP  (ATTACK_STEP),
         .RELEASE_STEP (RELEASE_STEP)
      ) u_env (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_tick    (w_tick),
         .i_load    (w_load    && (w_sel_idx == IDX_W'(i))),
         .i_retrig  (w_retrig  && (w_sel_idx == IDX_W'(i))),
         .i_release (w_release && (w_sel_idx == IDX_W'(i))),
         .i_target  (w_target),
         .o_state   (w_env_state[i]),
         .o_volume  (voice_volumes[i]),
         .o_active  (voice_active[i])
      );
      assign frequencies[i] = r_freq[i];
   end

   assign ev_ready   = r_ev_ready;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a fast envelope (ENV_DIV=4).
module tb_voice_allocator;

   localparam int unsigned NV = 8;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 ev_valid = 1'b0;
   logic                 ev_ready;
   logic                 ev_on = 1'b0;
   logic [6:0]           ev_note = '0;
   logic [6:0]           ev_velocity = '0;
   logic [31:0]          ev_freq = '0;
   logic [NV-1:0][31:0]  frequencies;
   logic [NV-1:0][31:0]  voice_volumes;
   logic [NV-1:0]        voice_active;
   logic [15:0]          drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   voice_allocator #(
      .NUM_VOICES   (NV),
      .ENV_DIV      (4),
      .ATTACK_STEP  (32'h0200_0000),
      .RELEASE_STEP (32'h0100_0000),
      .VOL_SHIFT    (24)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_on         (ev_on),
      .ev_note       (ev_note),
      .ev_velocity   (ev_velocity),
      .ev_freq       (ev_freq),
      .frequencies   (frequencies),
      .voice_volumes (voice_volumes),
      .voice_active  (voice_active),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulse reset between edges and release it on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Send one event and check the ready timing through SCAN and COMMIT.
   task automatic send_event(input logic on, input logic [6:0] note,
                             input logic [6:0] vel, input logic [31:0] freq);
      int w = 0;
      while (ev_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_event", 32'(ev_ready), 32'd1);
      ev_valid = 1'b1; ev_on = on; ev_note = note; ev_velocity = vel; ev_freq = freq;
      @(posedge clk);
      #1 ev_valid = 1'b0;
      @(negedge clk);
      check("ready_low_after_accept", 32'(ev_ready), 32'd0);
      repeat (NV) @(negedge clk);
      check("ready_low_last_scan", 32'(ev_ready), 32'd0);
      @(negedge clk);
      check("ready_high_after_commit", 32'(ev_ready), 32'd1);
   endtask

   // Wait (bounded) for a voice volume to move away from prev.
   task automatic wait_vol_change(input int idx, input logic [31:0] prev, output logic [31:0] val);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (voice_volumes[idx] !== prev) break;
      end
      val = voice_volumes[idx];
   endtask

   initial begin
      logic [31:0] v;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst_ready", 32'(ev_ready), 32'd0);
      check("rst_freq0", frequencies[0], 32'd1);
      check("rst_vol0", voice_volumes[0], 32'd0);
      check("rst_active", 32'(voice_active), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: note-on, attack to sustain
      send_event(1'b1, 7'd60, 7'd4, 32'd440);
      check("t1_freq0", frequencies[0], 32'd440);
      check("t1_vol0_start", voice_volumes[0], 32'd0);
      check("t1_active", 32'(voice_active), 32'h01);
      wait_vol_change(0, 32'd0, v);          check("t1_attack1", v, 32'h0200_0000);
      wait_vol_change(0, 32'h0200_0000, v);  check("t1_attack2", v, 32'h0400_0000);
      repeat (12) @(negedge clk);
      check("t1_sustain_hold", voice_volumes[0], 32'h0400_0000);

      // 2: note-off, release to idle
      send_event(1'b0, 7'd60, 7'd0, 32'd0);
      check("t2_vol_at_release", voice_volumes[0], 32'h0400_0000);
      wait_vol_change(0, 32'h0400_0000, v);  check("t2_rel1", v, 32'h0300_0000);
      wait_vol_change(0, 32'h0300_0000, v);  check("t2_rel2", v, 32'h0200_0000);
      wait_vol_change(0, 32'h0200_0000, v);  check("t2_rel3", v, 32'h0100_0000);
      check("t2_active_in_release", 32'(voice_active), 32'h01);
      wait_vol_change(0, 32'h0100_0000, v);  check("t2_rel4", v, 32'd0);
      check("t2_inactive", 32'(voice_active), 32'h00);
      check("t2_freq_held", frequencies[0], 32'd440);

      // 3: fill all voices, then one more note-on
      do_reset();
      for (int n = 1; n <= 8; n++) send_event(1'b1, 7'(n), 7'd4, 32'(100 + n));
      check("t3_freq7", frequencies[7], 32'd108);
      check("t3_all_active", 32'(voice_active), 32'hFF);
      repeat (12) @(negedge clk);
      send_event(1'b1, 7'd9, 7'd4, 32'd109);
      check("t3_all_active_after", 32'(voice_active), 32'hFF);
`ifdef VOICE_ALLOC_STEAL_EN
      check("t3_steal_freq0", frequencies[0], 32'd109);
      check("t3_steal_vol0", voice_volumes[0], 32'd0);
      check("t3_steal_drop", 32'(drop_count), 32'd0);
`else
      check("t3_drop_freq0", frequencies[0], 32'd101);
      check("t3_drop_vol0", voice_volumes[0], 32'h0400_0000);
      check("t3_drop_count", 32'(drop_count), 32'd1);
`endif

      // 4: retrigger same note with higher velocity
      do_reset();
      send_event(1'b1, 7'd60, 7'd4, 32'd440);
      wait_vol_change(0, 32'd0, v);
      wait_vol_change(0, 32'h0200_0000, v);  check("t4_first_sustain", v, 32'h0400_0000);
      send_event(1'b1, 7'd60, 7'd8, 32'd523);
      check("t4_freq0", frequencies[0], 32'd523);
      check("t4_vol_kept", voice_volumes[0], 32'h0400_0000);
      check("t4_only_voice0", 32'(voice_active), 32'h01);
      wait_vol_change(0, 32'h0400_0000, v);  check("t4_attack1", v, 32'h0600_0000);
      wait_vol_change(0, 32'h0600_0000, v);  check("t4_attack2", v, 32'h0800_0000);
      repeat (12) @(negedge clk);
      check("t4_sustain_hold", voice_volumes[0], 32'h0800_0000);
      check("t4_freq1_untouched", frequencies[1], 32'd1);

      // 5: note-off for a note never played
      send_event(1'b0, 7'd99, 7'd0, 32'd0);
      check("t5_active", 32'(voice_active), 32'h01);
      check("t5_vol0", voice_volumes[0], 32'h0800_0000);
      check("t5_freq0", frequencies[0], 32'd523);
      check("t5_drop", 32'(drop_count), 32'd0);

      // 6: asynchronous reset in the middle of a scan
      @(negedge clk);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_velocity = 7'd4; ev_freq = 32'd700;
      @(posedge clk);
      #1 ev_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t6_ready", 32'(ev_ready), 32'd0);
      check("t6_active", 32'(voice_active), 32'd0);
      check("t6_drop", 32'(drop_count), 32'd0);
      for (int i = 0; i < NV; i++) begin
         check($sformatf("t6_freq%0d", i), frequencies[i], 32'd1);
         check($sformatf("t6_vol%0d", i), voice_volumes[i], 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("t6_ready_edge1", 32'(ev_ready), 32'd0);
      @(negedge clk);
      check("t6_ready_edge2", 32'(ev_ready), 32'd1);
      send_event(1'b1, 7'd71, 7'd4, 32'd880);
      check("t6_next_freq0", frequencies[0], 32'd880);
      check("t6_next_active", 32'(voice_active), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
